// File: rtl/monolith_pkg.sv
// Shared constants and FSM encoding for the Monolith sponge and its modular adder.
package monolith_pkg;

  localparam int DEF_WORD_WIDTH  = 31;
  localparam int DEF_STATE_SIZE  = 16;
  localparam int DEF_RATE        = 8;
  localparam int DEF_DIGEST_SIZE = 8;

  // Mersenne prime 2^31-1; every stored state word stays strictly below it.
  localparam logic [DEF_WORD_WIDTH-1:0] MODULUS_P = 31'h7FFF_FFFF;

  typedef enum logic [2:0] {
    IDLE,
    ABSORB,
    PAD,
    PERM_START,
    PERM_WAIT,
    PERM_CLEAR,
    SQUEEZE
  } sponge_state_e;

endpackage

// File: rtl/monolith_mod_add.sv
// Combinational canonical addition modulo the Mersenne prime 2^WIDTH-1.
// Operand a must already be canonical; operand b may equal the modulus and is folded to 0.
module monolith_mod_add
  import monolith_pkg::*;
#(
  parameter int WIDTH = DEF_WORD_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  localparam logic [WIDTH-1:0] MODULUS = '1;

  logic [WIDTH-1:0] b_canon;
  logic [WIDTH:0]   raw;

  always_comb begin
    b_canon = (b == MODULUS) ? '0 : b;
    raw     = {1'b0, a} + {1'b0, b_canon};
    // One conditional subtraction suffices because both operands are below the modulus.
    sum     = (raw >= {1'b0, MODULUS}) ? WIDTH'(raw - {1'b0, MODULUS}) : raw[WIDTH-1:0];
  end

endmodule

// File: rtl/monolith_sponge.sv
// Monolith sponge: absorbs field words, drives an external permutation engine and squeezes a digest.
// Define MONOLITH_SPONGE_PAD_EN to enable 10* padding through the PAD state.
module monolith_sponge
  import monolith_pkg::*;
#(
  parameter int WORD_WIDTH  = DEF_WORD_WIDTH,
  parameter int STATE_SIZE  = DEF_STATE_SIZE,
  parameter int RATE        = DEF_RATE,
  parameter int DIGEST_SIZE = DEF_DIGEST_SIZE
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [WORD_WIDTH-1:0]                  msg_data,
  input  logic                                   msg_valid,
  input  logic                                   msg_last,
  output logic                                   msg_ready,
  output logic [STATE_SIZE-1:0][WORD_WIDTH-1:0]  perm_state_out,
  output logic                                   perm_in_valid,
  input  logic [STATE_SIZE-1:0][WORD_WIDTH-1:0]  perm_state_in,
  input  logic                                   perm_out_valid,
  output logic                                   perm_clear,
  output logic [WORD_WIDTH-1:0]                  dig_data,
  output logic                                   dig_valid,
  input  logic                                   dig_ready,
  output logic                                   busy
);

  localparam int CNT_W = $clog2(RATE + 1);
  localparam int IDX_W = (DIGEST_SIZE > 1) ? $clog2(DIGEST_SIZE) : 1;
  localparam int SEL_W = (STATE_SIZE > 1) ? $clog2(STATE_SIZE) : 1;
  localparam logic [CNT_W-1:0] RATE_CNT = CNT_W'(RATE);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGEST_SIZE - 1);

  sponge_state_e                         fsm;
  logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] state_q;
  logic [CNT_W-1:0]                      cnt;
  logic [CNT_W-1:0]                      cnt_next;
  logic [IDX_W-1:0]                      idx;
  logic [IDX_W-1:0]                      idx_next;
  logic [SEL_W-1:0]                      cnt_sel;
  logic [SEL_W-1:0]                      idx_next_sel;
  logic                                  last_seen;
  logic [WORD_WIDTH-1:0]                 absorb_sum;

  assign cnt_next       = cnt + CNT_W'(1);
  assign idx_next       = idx + IDX_W'(1);
  assign cnt_sel        = SEL_W'(cnt);
  assign idx_next_sel   = SEL_W'(idx_next);
  assign perm_state_out = state_q;

  monolith_mod_add #(.WIDTH(WORD_WIDTH)) u_absorb_add (
    .a   (state_q[cnt_sel]),
    .b   (msg_data),
    .sum (absorb_sum)
  );

`ifdef MONOLITH_SPONGE_PAD_EN
  // Set once the padding 1 has been absorbed, so the next permutation return heads to SQUEEZE.
  logic                  padded;
  logic [WORD_WIDTH-1:0] pad_sum;

  monolith_mod_add #(.WIDTH(WORD_WIDTH)) u_pad_add (
    .a   (state_q[cnt_sel]),
    .b   (WORD_WIDTH'(1)),
    .sum (pad_sum)
  );
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm           <= IDLE;
      state_q       <= '0;
      cnt           <= '0;
      idx           <= '0;
      last_seen     <= 1'b0;
      msg_ready     <= 1'b0;
      perm_in_valid <= 1'b0;
      perm_clear    <= 1'b0;
      dig_valid     <= 1'b0;
      dig_data      <= '0;
      busy          <= 1'b0;
`ifdef MONOLITH_SPONGE_PAD_EN
      padded        <= 1'b0;
`endif
    end else begin
      perm_in_valid <= 1'b0;
      perm_clear    <= 1'b0;
      case (fsm)
        IDLE, ABSORB: begin
          msg_ready <= 1'b1;
          if (msg_valid && msg_ready) begin
            state_q[cnt_sel] <= absorb_sum;
            cnt              <= cnt_next;
            busy             <= 1'b1;
            if (msg_last) begin
              last_seen <= 1'b1;
              msg_ready <= 1'b0;
`ifdef MONOLITH_SPONGE_PAD_EN
              fsm       <= PAD;
`else
              fsm           <= PERM_START;
              perm_in_valid <= 1'b1;
`endif
            end else if (cnt_next == RATE_CNT) begin
              fsm           <= PERM_START;
              perm_in_valid <= 1'b1;
              msg_ready     <= 1'b0;
            end else begin
              fsm <= ABSORB;
            end
          end
        end
`ifdef MONOLITH_SPONGE_PAD_EN
        // A full final block is permuted first; the 1 then lands in word 0 of a fresh block.
        PAD: begin
          fsm           <= PERM_START;
          perm_in_valid <= 1'b1;
          if (cnt < RATE_CNT) begin
            state_q[cnt_sel] <= pad_sum;
            padded           <= 1'b1;
          end
        end
`endif
        PERM_START: begin
          fsm <= PERM_WAIT;
        end
        PERM_WAIT: begin
          if (perm_out_valid) begin
            state_q    <= perm_state_in;
            fsm        <= PERM_CLEAR;
            perm_clear <= 1'b1;
          end
        end
        PERM_CLEAR: begin
          cnt <= '0;
          if (!last_seen) begin
            fsm       <= ABSORB;
            msg_ready <= 1'b1;
          end
`ifdef MONOLITH_SPONGE_PAD_EN
          else if (!padded) begin
            fsm <= PAD;
          end
`endif
          else begin
            fsm       <= SQUEEZE;
            idx       <= '0;
            dig_valid <= 1'b1;
            dig_data  <= state_q[0];
          end
        end
        SQUEEZE: begin
          if (dig_ready) begin
            if (idx == IDX_LAST) begin
              fsm       <= IDLE;
              state_q   <= '0;
              cnt       <= '0;
              idx       <= '0;
              last_seen <= 1'b0;
              dig_valid <= 1'b0;
              dig_data  <= '0;
              busy      <= 1'b0;
              msg_ready <= 1'b1;
`ifdef MONOLITH_SPONGE_PAD_EN
              padded    <= 1'b0;
`endif
            end else begin
              idx      <= idx_next;
              dig_data <= state_q[idx_next_sel];
            end
          end
        end
        default: begin
          fsm <= IDLE;
        end
      endcase
    end
  end

endmodule
